// File: rtl/gpio_pkg.sv
// Shared constants for the parametrised GPIO bank.
// Register indices select within one port's 8-slot window.
package gpio_pkg;

  localparam int RD_W = 16;

  localparam logic [2:0] REG_IN    = 3'd0;
  localparam logic [2:0] REG_OUT   = 3'd1;
  localparam logic [2:0] REG_DIR   = 3'd2;
  localparam logic [2:0] REG_SET   = 3'd3;
  localparam logic [2:0] REG_CLR   = 3'd4;
  localparam logic [2:0] REG_TGL   = 3'd5;
  localparam logic [2:0] REG_EVT   = 3'd6;
  localparam logic [2:0] REG_EVTEN = 3'd7;

endpackage

// File: rtl/io_gpio_bank_if.sv
// IO-space bus bundle between the J1 strobes and the GPIO bank.
// addr[PSEL_W+2:3] picks the port, addr[2:0] the register.
interface io_gpio_bank_if #(
  parameter int PSEL_W = 3
);

  logic              io_rd;
  logic              io_wr;
  logic [PSEL_W+2:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;

  modport master (
    output io_rd,
    output io_wr,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  io_rd,
    input  io_wr,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/gpio_port.sv
// One GPIO port: synchroniser, OUT/DIR/EVTEN registers,
// atomic set/clear/toggle and W1C change-event flags.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       rsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic [RD_W-1:0]  rd_val,
  output logic             irq_term
);

  logic [WIDTH-1:0] sync;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync = pin_in;
  end else begin : g_sync
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = pin_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++)
          sync_q[i] <= '0;
      end else begin
        for (int i = 0; i < SYNC_STAGES; i++)
          sync_q[i] <= sync_d[i];
      end
    end

    assign sync = sync_q[SYNC_STAGES-1];
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic [WIDTH-1:0] evten_q, evten_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] rd_raw;

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    evten_d = evten_q;
    evt_clr = '0;
    if (wr_en) begin
      unique case (rsel)
        REG_OUT:   out_d   = wdata;
        REG_DIR:   dir_d   = wdata;
        REG_SET:   out_d   = out_q | wdata;
        REG_CLR:   out_d   = out_q & ~wdata;
        REG_TGL:   out_d   = out_q ^ wdata;
        REG_EVT:   evt_clr = wdata;
        REG_EVTEN: evten_d = wdata;
        default:   ;
      endcase
    end
    // a fresh edge beats a same-cycle W1C on that bit
    evt_d  = (evt_q & ~evt_clr) | (sync ^ prev_q);
    prev_d = sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      dir_q   <= '0;
      evt_q   <= '0;
      evten_q <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      evt_q   <= evt_d;
      evten_q <= evten_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    rd_raw = '0;
    unique case (rsel)
      REG_IN:    rd_raw = sync;
      REG_OUT,
      REG_SET,
      REG_CLR,
      REG_TGL:   rd_raw = out_q;
      REG_DIR:   rd_raw = dir_q;
      REG_EVT:   rd_raw = evt_q;
      REG_EVTEN: rd_raw = evten_q;
      default:   rd_raw = '0;
    endcase
  end

  assign rd_val   = RD_W'(rd_raw);
  assign pin_out  = out_q;
  assign pin_oe   = dir_q;
  assign irq_term = |(evt_q & evten_q);

endmodule

// File: rtl/io_gpio_bank.sv
// GPIO bank: PORTS identical ports behind the IO strobes,
// registered read data and a registered OR of port irqs.
module io_gpio_bank
  import gpio_pkg::*;
#(
  parameter int PORTS       = 3,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PSEL_W      = 3
) (
  input  logic                   clk,
  input  logic                   resetq,
  io_gpio_bank_if.slave          bus,
  input  logic [PORTS*WIDTH-1:0] pin_in,
  output logic [PORTS*WIDTH-1:0] pin_out,
  output logic [PORTS*WIDTH-1:0] pin_oe,
  output logic                   irq
);

  logic [PSEL_W-1:0] psel;
  logic [2:0]        rsel;
  logic [RD_W-1:0]   rd_vals [PORTS];
  logic [PORTS-1:0]  irq_terms;
  logic [PORTS-1:0]  wr_sel;

  assign psel = bus.addr[PSEL_W+2:3];
  assign rsel = bus.addr[2:0];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign wr_sel[p] = bus.io_wr && (psel == PSEL_W'(p));

    gpio_port #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk      (clk),
      .rst_n    (resetq),
      .wr_en    (wr_sel[p]),
      .rsel     (rsel),
      .wdata    (bus.wdata[WIDTH-1:0]),
      .pin_in   (pin_in[p*WIDTH +: WIDTH]),
      .pin_out  (pin_out[p*WIDTH +: WIDTH]),
      .pin_oe   (pin_oe[p*WIDTH +: WIDTH]),
      .rd_val   (rd_vals[p]),
      .irq_term (irq_terms[p])
    );
  end

  logic [RD_W-1:0] rd_mux;
  logic [RD_W-1:0] rdata_q, rdata_d;
  logic            irq_q, irq_d;

  // unmatched port index falls through to zero
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < PORTS; p++)
      if (psel == PSEL_W'(p))
        rd_mux = rd_vals[p];
  end

  always_comb begin
    rdata_d = bus.io_rd ? rd_mux : rdata_q;
    irq_d   = |irq_terms;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: doc/io_gpio_bank.md
Name: io_gpio_bank

Overview:
- Parametrised GPIO bank for the J1 IO space; replaces the hand-instantiated PMOD/header1/header2 port triplets with PORTS identical ports of WIDTH bits each.
- Each port has input synchronisation, output and direction registers, atomic set/clear/toggle writes, and per-bit change-event capture with a maskable interrupt.
- Sits behind the registered IO strobes in top; pin_* connect to SB_IO D_OUT_0/OUTPUT_ENABLE/D_IN_0.

Parameters:
- PORTS, 3, number of ports (1..8)
- WIDTH, 8, bits per port (1..16)
- SYNC_STAGES, 2, input synchroniser depth (0 = pass-through, for pins already registered in SB_IO)
- PSEL_W, 3, port-index field width; must satisfy 2**PSEL_W >= PORTS

Ports:
- clk  in  1  system clock
- resetq  in  1  asynchronous active-low reset
- io_rd  in  1  read strobe, one cycle
- io_wr  in  1  write strobe, one cycle
- addr  in  PSEL_W+3  [PSEL_W+2:3] = port index, [2:0] = register
- wdata  in  16  write data; bits above WIDTH ignored
- rdata  out  16  read data, zero-extended
- pin_in  in  PORTS*WIDTH  raw pin inputs; port p at [p*WIDTH +: WIDTH]
- pin_out  out  PORTS*WIDTH  output values
- pin_oe  out  PORTS*WIDTH  output enables (1 = drive)
- irq  out  1  OR of all (EVT & EVTEN)

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on resetq. All state is cleared when resetq is low. OUT=0, DIR=0 (all inputs), EVT=0, EVTEN=0, synchroniser FFs=0, rdata=0, irq=0.
- Register map per port:
  - 0 IN (read-only, synchronised input)
  - 1 OUT (R/W)
  - 2 DIR (R/W)
  - 3 SET: OUT |= wdata; reads return OUT
  - 4 CLR: OUT &= ~wdata; reads return OUT
  - 5 TGL: OUT ^= wdata; reads return OUT
  - 6 EVT: read returns flags; a write clears the bits where wdata is 1 (W1C)
  - 7 EVTEN (R/W)
- Writes to IN are ignored.
- pin_out = OUT and pin_oe = DIR, driven straight from registers with no combinational path from the bus.
- Synchroniser: sync = SYNC_STAGES-deep shift of pin_in. With the default depth, IN reflects a pin change 2 cycles after it appears at pin_in.
- Event capture:
  - prev <= sync every cycle.
  - EVT[i] sets when sync[i] != prev[i], whether or not EVTEN is set.
  - prev resets to 0. A pin held high through reset therefore raises EVT on the first cycles after release; software clears it.
- Simultaneous W1C clear and new edge on the same bit in the same cycle: the set wins and the flag stays 1.
- Read latency:
  - rdata is registered. It is updated on the clk edge where io_rd=1 and is valid the cycle after the strobe.
  - rdata holds its value until the next io_rd.
  - Reading EVT has no side effects.
- Out-of-range port index (>= PORTS): writes are ignored; reads return 0.
- io_rd and io_wr asserted together: the write is performed, and rdata captures the pre-write value.
- irq is registered: irq <= |(EVT & EVTEN) over all ports. It asserts 1 cycle after EVT sets and deasserts 1 cycle after the clearing write.

Decomposition:
- Package gpio_pkg holds:
  - register index constants: REG_IN, REG_OUT, REG_DIR, REG_SET, REG_CLR, REG_TGL, REG_EVT, REG_EVTEN
  - RD_W=16
- Sub-module gpio_port: one port's registers, synchroniser, edge detector and local irq term; instantiated PORTS times by a generate loop.
- Top level decodes the port index, muxes rdata and ORs the irq terms.

Test Plan:
- Reset state: hold resetq low mid-operation with OUT=0xFF -> pin_out=0, pin_oe=0, irq=0 immediately (asynchronous); after release, read DIR -> 0x0000.
- Atomic ops on port 1: write OUT=0x0F, SET 0x30, CLR 0x01, TGL 0x81 -> read OUT = 0xBF on the cycle after io_rd.
- Input path on port 2: pin_in bit 3 goes 0->1 at cycle t.
  - IN reads 0x0008 when sampled from t+2 onward.
  - EVT=0x0008.
  - With EVTEN=0x0008, irq rises one cycle after the EVT flag sets.
- W1C race: write EVT=0x0008 in the same cycle that a new edge on bit 3 is captured -> EVT stays 0x0008 and irq stays 1. A repeat write with no edge -> EVT=0, and irq falls the next cycle.
- Range and masking with PORTS=3: write OUT on port index 5 -> no state change and read returns 0. Write 0xFFFF to OUT with WIDTH=8 -> read returns 0x00FF.
- Parameter sweep: PORTS=1/WIDTH=16/SYNC_STAGES=0 -> IN follows pin_in with 0 cycles of synchroniser delay, and all registers pass at full 16-bit width.
